input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//   Per-channel conditioning for asynchronous inputs such as buttons and switches: an N-stage
//   synchronizer, a debouncer based on a shared sample tick, and rising/falling edge pulses.
//   Sits between the board I/O pins and the core/MMIO logic, replacing bare 2-FF synchronizers on noisy inputs.
// PARAMETERS
//   WIDTH          1   number of independent channels
//   STAGES         2   synchronizer flops per channel; legal values are >= 2
//   SAMPLE_CNT_MAX 1   clock cycles per sample tick; legal values are >= 1 (1 = a tick every cycle)
//   PULSE_CNT_MAX  1   consecutive disagreeing ticks needed to flip the debounced state; legal values are >= 1
//   DEBOUNCE_EN    1   1 = debouncer active; 0 = debounced_out wired straight to sync_out (bypass)
// PORTS
//   clk           in   1      single clock, rising edge
//   rst           in   1      asynchronous, active-high reset
//   async_in      in   WIDTH  raw asynchronous inputs
//   sync_out      out  WIDTH  synchronized inputs (last stage of each chain)
//   debounced_out out  WIDTH  debounced level per channel
//   rise_pulse    out  WIDTH  one-cycle pulse on each 0->1 transition of debounced_out
//   fall_pulse    out  WIDTH  one-cycle pulse on each 1->0 transition of debounced_out
// BEHAVIOUR
//   Reset
//   - rst asynchronously clears every flop: sync chains, tick counter, per-channel counters,
//     debounced state and the previous-state register.
//   - All outputs read 0 while rst is high and in the first cycle after release.
//   Synchronizer
//   - Per channel, a STAGES-deep shift register; sync_out = last stage.
//   - Latency: exactly STAGES rising edges from async_in being sampled.
//   - No logic is placed between the stages.
//   Sample tick (shared by all channels)
//   - tick_cnt counts 0..SAMPLE_CNT_MAX-1 and wraps to 0.
//   - tick is high in the cycle where tick_cnt == SAMPLE_CNT_MAX-1.
//   - After reset, the first tick falls on the SAMPLE_CNT_MAX-th cycle.
//   - Counter width is $clog2(SAMPLE_CNT_MAX) (minimum 1).
//   Debouncer (per channel; states STABLE / PENDING, encoded as cnt == 0 or cnt != 0)
//   - In any cycle where sync_out[i] == debounced_out[i]: cnt[i] <= 0, regardless of tick.
//   - In a cycle where tick is high and the bits disagree:
//       if cnt[i] == PULSE_CNT_MAX-1: debounced_out[i] <= ~debounced_out[i] and cnt[i] <= 0;
//       otherwise: cnt[i] <= cnt[i]+1.
//   - In a cycle where tick is low and the bits disagree: cnt[i] holds.
//   - Counter width is $clog2(PULSE_CNT_MAX) (minimum 1). The counter never exceeds PULSE_CNT_MAX-1.
//   - The scheme is symmetric: press and release get the same filtering.
//   - DEBOUNCE_EN=0: debounced_out = sync_out; the counters are unused.
//   Edge detection
//   - prev[i] is debounced_out[i] registered one cycle.
//   - rise_pulse = debounced_out & ~prev; fall_pulse = ~debounced_out & prev.
//   - Each pulse is high for exactly 1 cycle: the first cycle debounced_out shows the new value.
//   - rise_pulse and fall_pulse are never both high on the same channel.
//   Boundary cases
//   - Channels are fully independent and may toggle in the same cycle.
//   - rst asserted mid-count discards the partial count.
//   - rst asserted while debounced_out=1 clears the output immediately and produces no fall_pulse.
// TESTING  (WIDTH=2, STAGES=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, DEBOUNCE_EN=1 unless stated)
//   1. rst high 5 cycles with async_in=2'b11, then release with async_in=2'b00
//      -> all outputs 0 throughout; no pulses in the following 50 cycles.
//   2. async_in[0] steps 0->1 and holds
//      -> sync_out[0] rises 2 cycles later; debounced_out[0] rises on the 3rd tick after that,
//         i.e. 9-12 cycles after sync_out[0];
//      -> rise_pulse[0] high exactly 1 cycle; channel 1 unaffected.
//   3. async_in[1] toggles every 5 cycles for 60 cycles (bounce)
//      -> debounced_out[1] stays 0; zero rise/fall pulses.
//   4. From debounced_out[0]=1, drop async_in[0] to 0 and hold
//      -> fall_pulse[0] for 1 cycle 9-12 cycles after sync_out[0] falls; no rise_pulse.
//   5. async_in=2'b11 held for 2 ticks, pulse rst for 1 cycle, keep 2'b11
//      -> 3 full ticks are needed again before both rise_pulse bits fire in the same cycle.
//   6. DEBOUNCE_EN=0, SAMPLE_CNT_MAX=1: step async_in[0] 0->1
//      -> debounced_out[0] = sync_out[0]; rise_pulse[0] in the cycle sync_out[0] first reads 1.

Source files
------------

// File: rtl/input_conditioner.sv
// Per-channel input conditioning: N-stage synchronizer, tick-based debouncer and
// one-cycle rise/fall pulses on the debounced level.
module input_conditioner #(
  parameter int WIDTH          = 1,
  parameter int STAGES         = 2,
  parameter int SAMPLE_CNT_MAX = 1,
  parameter int PULSE_CNT_MAX  = 1,
  parameter int DEBOUNCE_EN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] debounced_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  logic [WIDTH-1:0] prev;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sync
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        chain <= '0;
      end else begin
        chain <= {chain[STAGES-2:0], async_in[i]};
      end
    end

    assign sync_out[i] = chain[STAGES-1];
  end

  if (DEBOUNCE_EN != 0) begin : g_debounce
    localparam int TW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam int CW = (PULSE_CNT_MAX > 1) ? $clog2(PULSE_CNT_MAX) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(SAMPLE_CNT_MAX - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CNT_MAX - 1);

    logic [TW-1:0]    tick_cnt;
    logic             tick;
    logic [WIDTH-1:0] level;

    assign tick = (tick_cnt == TICK_LAST);

    // One shared sample tick paces every channel's debounce counter.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tick_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      logic [CW-1:0] cnt;
      logic          state;

      // Any agreeing cycle discards the run, so bounce restarts the count.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt   <= '0;
          state <= 1'b0;
        end else if (sync_out[i] == state) begin
          cnt <= '0;
        end else if (tick) begin
          if (cnt == PULSE_LAST) begin
            cnt   <= '0;
            state <= ~state;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign level[i] = state;
    end

    assign debounced_out = level;
  end else begin : g_bypass
    assign debounced_out = sync_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= '0;
    end else begin
      prev <= debounced_out;
    end
  end

  assign rise_pulse = debounced_out & ~prev;
  assign fall_pulse = ~debounced_out & prev;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: a debouncing instance (2 channels, tick every
// 4 cycles, 3 ticks to flip) and a bypass instance sharing clock and reset.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] async_in;
  logic [1:0] sync_out;
  logic [1:0] debounced_out;
  logic [1:0] rise_pulse;
  logic [1:0] fall_pulse;
  logic       byp_in;
  logic [0:0] byp_sync;
  logic [0:0] byp_deb;
  logic [0:0] byp_rise;
  logic [0:0] byp_fall;

  int checks = 0;
  int passed = 0;

  input_conditioner #(
    .WIDTH(2), .STAGES(2), .SAMPLE_CNT_MAX(4), .PULSE_CNT_MAX(3), .DEBOUNCE_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .async_in(async_in), .sync_out(sync_out),
    .debounced_out(debounced_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
  );

  input_conditioner #(
    .WIDTH(1), .STAGES(2), .SAMPLE_CNT_MAX(1), .PULSE_CNT_MAX(1), .DEBOUNCE_EN(0)
  ) byp (
    .clk(clk), .rst(rst), .async_in(byp_in), .sync_out(byp_sync),
    .debounced_out(byp_deb), .rise_pulse(byp_rise), .fall_pulse(byp_fall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] main_in, input logic bypass_in);
    async_in = main_in;
    byp_in   = bypass_in;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] s, input logic [1:0] d,
                             input logic [1:0] r, input logic [1:0] f);
    checks++;
    assert ({sync_out, debounced_out, rise_pulse, fall_pulse} === {s, d, r, f})
      passed = passed + 1;
    else
      $error("[TB] FAIL %s: sync/deb/rise/fall observed %b/%b/%b/%b, expected %b/%b/%b/%b",
             tag, sync_out, debounced_out, rise_pulse, fall_pulse, s, d, r, f);
  endtask

  // Used while channel 1's synchronizer is bouncing and its sync level is not of interest.
  task automatic checkLevel(input string tag, input logic [1:0] d, input logic [1:0] r,
                            input logic [1:0] f);
    checks++;
    assert ({debounced_out, rise_pulse, fall_pulse} === {d, r, f})
      passed = passed + 1;
    else
      $error("[TB] FAIL %s: deb/rise/fall observed %b/%b/%b, expected %b/%b/%b",
             tag, debounced_out, rise_pulse, fall_pulse, d, r, f);
  endtask

  task automatic checkBypass(input string tag, input logic s, input logic d,
                             input logic r, input logic f);
    checks++;
    assert ({byp_sync, byp_deb, byp_rise, byp_fall} === {s, d, r, f})
      passed = passed + 1;
    else
      $error("[TB] FAIL %s: sync/deb/rise/fall observed %b/%b/%b/%b, expected %b/%b/%b/%b",
             tag, byp_sync, byp_deb, byp_rise, byp_fall, s, d, r, f);
  endtask

  initial begin
    // Reset held with inputs high: nothing may leak through.
    rst = 1'b1;
    applyStimulus(2'b11, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step_cycle();
      checkOutput("reset_hold", 2'b00, 2'b00, 2'b00, 2'b00);
      checkBypass("reset_hold_byp", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    applyStimulus(2'b00, 1'b0);
    #1;
    checkOutput("release_first", 2'b00, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 50; i++) begin
      step_cycle();
      checkOutput("idle", 2'b00, 2'b00, 2'b00, 2'b00);
      checkBypass("idle_byp", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Channel 0 press: sync after 2 edges, level flips on the 3rd tick (edge 64).
    applyStimulus(2'b01, 1'b0);
    step_cycle();
    checkOutput("press_sync_lat", 2'b00, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 12; i++) begin
      step_cycle();
      checkOutput("press_pending", 2'b01, 2'b00, 2'b00, 2'b00);
    end
    step_cycle();
    checkOutput("press_rise", 2'b01, 2'b01, 2'b01, 2'b00);
    for (int i = 0; i < 6; i++) begin
      step_cycle();
      checkOutput("press_hold", 2'b01, 2'b01, 2'b00, 2'b00);
    end

    // Channel 1 bounces every 5 cycles: at most 2 ticks per high run, never flips.
    for (int seg = 0; seg < 12; seg++) begin
      applyStimulus({(seg % 2 == 0), 1'b1}, 1'b0);
      for (int i = 0; i < 5; i++) begin
        step_cycle();
        checkLevel("bounce", 2'b01, 2'b00, 2'b00);
      end
    end
    applyStimulus(2'b01, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      checkOutput("bounce_settle", 2'b01, 2'b01, 2'b00, 2'b00);
    end

    // Channel 0 release: sync falls at edge 135, level falls on the 3rd tick (edge 144).
    applyStimulus(2'b00, 1'b0);
    step_cycle();
    checkOutput("release_sync_lat", 2'b01, 2'b01, 2'b00, 2'b00);
    for (int i = 0; i < 9; i++) begin
      step_cycle();
      checkOutput("release_pending", 2'b00, 2'b01, 2'b00, 2'b00);
    end
    step_cycle();
    checkOutput("release_fall", 2'b00, 2'b00, 2'b00, 2'b01);
    for (int i = 0; i < 4; i++) begin
      step_cycle();
      checkOutput("release_hold", 2'b00, 2'b00, 2'b00, 2'b00);
    end

    // Both channels high for 2 ticks, then a reset pulse discards the partial count.
    applyStimulus(2'b11, 1'b0);
    step_cycle();
    checkOutput("both_sync_lat", 2'b00, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 7; i++) begin
      step_cycle();
      checkOutput("both_pending", 2'b11, 2'b00, 2'b00, 2'b00);
    end
    rst = 1'b1;
    #1;
    checkOutput("midcount_rst_async", 2'b00, 2'b00, 2'b00, 2'b00);
    step_cycle();
    checkOutput("midcount_rst_hold", 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    checkOutput("midcount_release", 2'b00, 2'b00, 2'b00, 2'b00);
    step_cycle();
    checkOutput("restart_sync_lat", 2'b00, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 10; i++) begin
      step_cycle();
      checkOutput("restart_pending", 2'b11, 2'b00, 2'b00, 2'b00);
    end
    step_cycle();
    checkOutput("restart_rise_both", 2'b11, 2'b11, 2'b11, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      checkOutput("restart_hold", 2'b11, 2'b11, 2'b00, 2'b00);
    end

    // Reset while the level is high clears it with no fall pulse.
    rst = 1'b1;
    #1;
    checkOutput("high_rst_async", 2'b00, 2'b00, 2'b00, 2'b00);
    step_cycle();
    checkOutput("high_rst_hold", 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    applyStimulus(2'b00, 1'b0);
    step_cycle();
    checkOutput("high_rst_after", 2'b00, 2'b00, 2'b00, 2'b00);

    // Bypass instance: debounced level tracks sync with pulses on its edges.
    applyStimulus(2'b00, 1'b1);
    step_cycle();
    checkBypass("byp_sync_lat", 1'b0, 1'b0, 1'b0, 1'b0);
    step_cycle();
    checkBypass("byp_rise", 1'b1, 1'b1, 1'b1, 1'b0);
    step_cycle();
    checkBypass("byp_hold_high", 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b00, 1'b0);
    step_cycle();
    checkBypass("byp_fall_lat", 1'b1, 1'b1, 1'b0, 1'b0);
    step_cycle();
    checkBypass("byp_fall", 1'b0, 1'b0, 1'b0, 1'b1);
    step_cycle();
    checkBypass("byp_hold_low", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
